// File: rtl/axis_frame_arb_mux.sv
// Round-robin, frame-granular AXI-Stream arbiter: S_COUNT sources share one sink, grant held until tlast.
// Latency: 1 cycle arbitration in IDLE, then 1 registered output stage (1 beat/cycle while granted).
// Backpressure: granted source sees tready = !m_axis_tvalid || m_axis_tready; all others held off.
module axis_frame_arb_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             grant_valid,
  output logic [ID_WIDTH-1:0]              grant_index
);

  // Request vector padded to a power of two so an ID_WIDTH index always fits exactly.
  localparam int PAD_COUNT = 1 << ID_WIDTH;

  typedef logic [ID_WIDTH-1:0] id_t;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state;
  id_t                   last_grant;
  logic [PAD_COUNT-1:0]  req_pad;
  id_t                   cand;
  id_t                   winner;
  logic                  found;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  src_rdy;
  logic                  accept;

  // Round-robin search starting just after the last winner, wrapping at S_COUNT.
  always_comb begin
    req_pad                = '0;
    req_pad[S_COUNT-1:0]   = s_axis_tvalid;
    found                  = 1'b0;
    winner                 = '0;
    cand = (last_grant == id_t'(S_COUNT - 1)) ? '0 : last_grant + id_t'(1);
    for (int k = 0; k < S_COUNT; k++) begin
      if (!found && req_pad[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == id_t'(S_COUNT - 1)) ? '0 : cand + id_t'(1);
    end
  end

  // Steer the granted source's beat toward the output register.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == id_t'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Only the granted source may see ready, and only when the output stage can take a beat.
  always_comb begin
    s_axis_tready = '0;
    src_rdy       = !m_axis_tvalid || m_axis_tready;
    if (state == ACTIVE) begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (grant_index == id_t'(i)) begin
          s_axis_tready[i] = src_rdy;
        end
      end
    end
  end

  assign accept = (state == ACTIVE) && sel_valid && src_rdy;

  // Grant FSM: arbitrate in IDLE, hold the grant through the accepted tlast beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_index <= '0;
      last_grant  <= id_t'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= ACTIVE;
            grant_valid <= 1'b1;
            grant_index <= winner;
            last_grant  <= winner;
          end
        end
        ACTIVE: begin
          if (accept && sel_last) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Output pipeline register: load on accept, drop valid once the sink drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tlast  <= sel_last;
      m_axis_tuser  <= sel_user;
      m_axis_tid    <= grant_index;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Bench for axis_frame_arb_mux: a 4-source instance and a 1-source instance sharing clock and reset.
// Directed table for the basic frame/rotation behaviour, plus a small source model for stalls and resets.
// Expected values come from the bench's own model of the frame and arbitration behaviour.
module tb_axis_frame_arb_mux;

  logic clk;
  logic rst;

  // 4-source instance
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tuser;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [1:0]   m_tid;
  logic [0:0]   m_tuser;
  logic         gv;
  logic [1:0]   gi;

  // 1-source instance
  logic [63:0]  b_tdata;
  logic [7:0]   b_tkeep;
  logic         b_tvalid;
  logic         b_tready;
  logic         b_tlast;
  logic         b_tuser;
  logic [63:0]  bm_tdata;
  logic [7:0]   bm_tkeep;
  logic         bm_tvalid;
  logic         bm_tready;
  logic         bm_tlast;
  logic [0:0]   bm_tid;
  logic [0:0]   bm_tuser;
  logic         b_gv;
  logic [0:0]   b_gi;

  axis_frame_arb_mux #(.S_COUNT(4), .DATA_WIDTH(64)) dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tuser(m_tuser), .grant_valid(gv), .grant_index(gi)
  );

  axis_frame_arb_mux #(.S_COUNT(1), .DATA_WIDTH(64)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
    .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep), .m_axis_tvalid(bm_tvalid),
    .m_axis_tready(bm_tready), .m_axis_tlast(bm_tlast), .m_axis_tid(bm_tid),
    .m_axis_tuser(bm_tuser), .grant_valid(b_gv), .grant_index(b_gi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- source model for the 4-source instance ----------------
  int flen[4];
  int frames[4];
  int beat[4];
  int fsent[4];
  bit gate[4];

  typedef struct {
    logic [1:0]  tid;
    logic [63:0] d;
    logic        l;
  } beat_t;
  beat_t q[$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      flen[i] = 1; frames[i] = 0; beat[i] = 0; fsent[i] = 0; gate[i] = 1'b0;
    end
  endtask

  task automatic drive_model();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = gate[i] && (frames[i] > 0);
      s_tlast[i]  = (beat[i] == flen[i] - 1);
      s_tdata[i*64 +: 64] = 64'(i * 16 + beat[i] + 256 * fsent[i]);
    end
  endtask

  // One clock: drive at posedge+1, sample at negedge, advance the model after the edge.
  task automatic run_cycle();
    bit acc[4];
    beat_t b;
    drive_model();
    @(negedge clk);
    for (int i = 0; i < 4; i++) acc[i] = s_tvalid[i] && s_tready[i];
    if (m_tvalid && m_tready) begin
      b.tid = m_tid; b.d = m_tdata; b.l = m_tlast;
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        beat[i]++;
        if (beat[i] == flen[i]) begin
          beat[i] = 0;
          frames[i]--;
          fsent[i]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0;
    m_tready = 1'b1; bm_tready = 1'b1;
    model_clear();
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] d;
    logic       gv;
    logic [1:0] gi;
    logic [3:0] rdy;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic [1:0] tid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] d,
                              input logic egv, input logic [1:0] egi, input logic [3:0] rdy,
                              input logic mv, input logic [7:0] md, input logic ml,
                              input logic [1:0] tid);
    vec_t v;
    v.vld = vld; v.lst = lst; v.d = d; v.gv = egv; v.gi = egi; v.rdy = rdy;
    v.mv = mv; v.md = md; v.ml = ml; v.tid = tid;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    bit ok;
    int cyc[$];
    logic [63:0] bdat[$];
    int cnt;
    bit bacc;

    rst = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0; bm_tready = 1'b1;
    for (int i = 0; i < 4; i++) s_tkeep[i*8 +: 8] = 8'hF0 | 8'(i);
    s_tuser = 4'b1010;
    b_tkeep = 8'hFF;
    b_tuser = 1'b1;

    // Source 2 three-beat frame, then 0 and 3 request together (pointer at 2 -> 3 wins, then 0).
    //            vld      lst      d      gv  gi   rdy      mv  md     ml  tid
    tbl[0]  = mk(4'b0100, 4'b0000, 8'hA0, 0, 2'd0, 4'b0000, 0, 8'h00, 0, 2'd0);
    tbl[1]  = mk(4'b0100, 4'b0000, 8'hA0, 1, 2'd2, 4'b0100, 0, 8'h00, 0, 2'd0);
    tbl[2]  = mk(4'b0100, 4'b0000, 8'hA1, 1, 2'd2, 4'b0100, 1, 8'hA0, 0, 2'd2);
    tbl[3]  = mk(4'b0100, 4'b0100, 8'hA2, 1, 2'd2, 4'b0100, 1, 8'hA1, 0, 2'd2);
    tbl[4]  = mk(4'b0000, 4'b0000, 8'h00, 0, 2'd0, 4'b0000, 1, 8'hA2, 1, 2'd2);
    tbl[5]  = mk(4'b0000, 4'b0000, 8'h00, 0, 2'd0, 4'b0000, 0, 8'h00, 0, 2'd0);
    tbl[6]  = mk(4'b1001, 4'b1001, 8'h55, 0, 2'd0, 4'b0000, 0, 8'h00, 0, 2'd0);
    tbl[7]  = mk(4'b1001, 4'b1001, 8'h55, 1, 2'd3, 4'b1000, 0, 8'h00, 0, 2'd0);
    tbl[8]  = mk(4'b0001, 4'b0001, 8'h66, 0, 2'd0, 4'b0000, 1, 8'h55, 1, 2'd3);
    tbl[9]  = mk(4'b0001, 4'b0001, 8'h66, 1, 2'd0, 4'b0001, 0, 8'h00, 0, 2'd0);
    tbl[10] = mk(4'b0000, 4'b0000, 8'h00, 0, 2'd0, 4'b0000, 1, 8'h66, 1, 2'd0);
    tbl[11] = mk(4'b0000, 4'b0000, 8'h00, 0, 2'd0, 4'b0000, 0, 8'h00, 0, 2'd0);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gv", gv, 0);
    chk("rst_mv", m_tvalid, 0);
    chk("rst_rdy", s_tready, 0);
    chk("rst_gi", gi, 0);
    chk("rst1_gv", b_gv, 0);
    chk("rst1_mv", bm_tvalid, 0);
    chk("rst1_rdy", b_tready, 0);
    @(posedge clk);
    #1;

    // Table-driven run
    for (int r = 0; r < 12; r++) begin
      s_tvalid = tbl[r].vld;
      s_tlast  = tbl[r].lst;
      for (int i = 0; i < 4; i++) s_tdata[i*64 +: 64] = {56'd0, tbl[r].d};
      m_tready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gv", r), gv, tbl[r].gv);
      if (tbl[r].gv) chk($sformatf("tbl%0d_gi", r), gi, tbl[r].gi);
      chk($sformatf("tbl%0d_rdy", r), s_tready, tbl[r].rdy);
      chk($sformatf("tbl%0d_mv", r), m_tvalid, tbl[r].mv);
      if (tbl[r].mv) begin
        chk($sformatf("tbl%0d_md", r), m_tdata, {56'd0, tbl[r].md});
        chk($sformatf("tbl%0d_ml", r), m_tlast, tbl[r].ml);
        chk($sformatf("tbl%0d_tid", r), m_tid, tbl[r].tid);
        chk($sformatf("tbl%0d_keep", r), m_tkeep, 8'hF0 | {6'd0, tbl[r].tid});
        chk($sformatf("tbl%0d_user", r), m_tuser, tbl[r].tid[0]);
      end
      @(posedge clk);
      #1;
    end

    // All four sources continuously requesting 2-beat frames
    do_reset();
    for (int i = 0; i < 4; i++) begin frames[i] = 5; flen[i] = 2; gate[i] = 1'b1; end
    for (int t = 0; t < 200; t++) begin
      run_cycle();
      if (q.size() >= 10) break;
    end
    ok = (q.size() >= 10);
    chk("rr_done", ok, 1);
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("rr%0d_tid", k), q[k].tid, (k / 2) % 4);
        chk($sformatf("rr%0d_d", k), q[k].d, 64'(((k / 2) % 4) * 16 + (k % 2) + 256 * (k / 8)));
        chk($sformatf("rr%0d_last", k), q[k].l, k % 2);
      end
    end

    // Output stall mid-frame on source 1
    do_reset();
    frames[1] = 1; flen[1] = 4; gate[1] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      run_cycle();
      if (m_tvalid && m_tdata == 64'd17) begin ok = 1'b1; break; end
    end
    chk("stall_reach", ok, 1);
    m_tready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      run_cycle();
      chk($sformatf("stall%0d_mv", t), m_tvalid, 1);
      chk($sformatf("stall%0d_md", t), m_tdata, 64'd17);
      chk($sformatf("stall%0d_rdy1", t), s_tready[1], 0);
    end
    m_tready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      run_cycle();
      if (frames[1] == 0 && !m_tvalid) break;
    end
    chk("stall_count", q.size(), 4);
    if (q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("stall_out%0d_d", k), q[k].d, 64'(16 + k));
        chk($sformatf("stall_out%0d_last", k), q[k].l, (k == 3));
        chk($sformatf("stall_out%0d_tid", k), q[k].tid, 1);
      end
    end

    // Granted source 3 goes idle mid-frame while source 0 requests
    do_reset();
    frames[3] = 1; flen[3] = 4; gate[3] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      run_cycle();
      if (beat[3] == 2) break;
    end
    chk("hold_reach", beat[3], 2);
    gate[3] = 1'b0;
    frames[0] = 1; flen[0] = 2; gate[0] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_cycle();
      chk($sformatf("hold%0d_gv", t), gv, 1);
      chk($sformatf("hold%0d_gi", t), gi, 3);
      chk($sformatf("hold%0d_rdy0", t), s_tready[0], 0);
    end
    gate[3] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      run_cycle();
      if (q.size() >= 6) break;
    end
    chk("hold_count", q.size(), 6);
    if (q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("hold_out%0d_tid", k), q[k].tid, (k < 4) ? 3 : 0);
        chk($sformatf("hold_out%0d_d", k), q[k].d, (k < 4) ? 64'(48 + k) : 64'(k - 4));
        chk($sformatf("hold_out%0d_last", k), q[k].l, (k == 3) || (k == 5));
      end
    end

    // Reset during the second beat of source 2's 4-beat frame
    do_reset();
    frames[2] = 1; flen[2] = 4; gate[2] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      run_cycle();
      if (beat[2] == 1) break;
    end
    chk("mrst_reach", beat[2], 1);
    rst = 1'b1;
    run_cycle();
    chk("mrst_mv", m_tvalid, 0);
    chk("mrst_gv", gv, 0);
    chk("mrst_rdy", s_tready, 0);
    rst = 1'b0;
    model_clear();
    frames[0] = 1; frames[3] = 1; gate[0] = 1'b1; gate[3] = 1'b1;
    run_cycle();
    chk("mrst_regrant_gv", gv, 1);
    chk("mrst_regrant_gi", gi, 0);

    // Single-source instance, back-to-back single-beat frames
    do_reset();
    cnt = 0;
    b_tvalid = 1'b1;
    b_tlast  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      b_tdata = 64'(cnt);
      @(negedge clk);
      bacc = b_tvalid && b_tready;
      if (bm_tvalid) begin
        cyc.push_back(c);
        bdat.push_back(bm_tdata);
        chk($sformatf("s1_c%0d_tid", c), bm_tid, 0);
        chk($sformatf("s1_c%0d_last", c), bm_tlast, 1);
      end
      @(posedge clk);
      #1;
      if (bacc) cnt++;
    end
    chk("s1_count", cyc.size(), 9);
    if (cyc.size() == 9) begin
      chk("s1_first_cycle", cyc[0], 2);
      for (int j = 0; j < 9; j++) begin
        chk($sformatf("s1_beat%0d_d", j), bdat[j], 64'(j));
        if (j > 0) chk($sformatf("s1_beat%0d_gap", j), cyc[j] - cyc[j-1], 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_arb_mux.md
Name: axis_frame_arb_mux

Overview:
- Round-robin, frame-granular arbiter that shares one AXI-Stream sink (typically an axis_fifo in the C2H DMA path) between S_COUNT AXI-Stream sources.
- A grant is held from the first beat of a frame through its tlast beat, so frames are never interleaved.
- Output passes through a single registered stage.
- m_axis_tid carries the index of the winning source so downstream logic can demultiplex completions.

Parameters:
- S_COUNT, 4, number of input streams (1..16)
- DATA_WIDTH, 64, tdata width in bits
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 1, tuser width
- ID_WIDTH, $clog2(S_COUNT) (minimum 1), width of m_axis_tid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed source data; source i is at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed tkeep
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT  per-source last
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed tuser
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tid  out  ID_WIDTH  source index of the current beat
- m_axis_tuser  out  USER_WIDTH  output user
- grant_valid  out  1  a grant is currently held
- grant_index  out  ID_WIDTH  index of the granted source

Behaviour:
- Reset values:
  - FSM enters IDLE.
  - grant_valid=0, grant_index=0, m_axis_tvalid=0, s_axis_tready=0.
  - Round-robin pointer last_grant=S_COUNT-1, so source 0 has first priority.
  - m_axis_tdata/tkeep/tlast/tuser/tid are don't-care while tvalid=0.
- FSM states are IDLE and ACTIVE.
- IDLE:
  - If any s_axis_tvalid is high, select the first asserted source searching from (last_grant+1) mod S_COUNT upward with wrap.
  - Next cycle: grant_index = winner, grant_valid=1, state ACTIVE, last_grant = winner.
  - No request: stay in IDLE.
  - Arbitration latency is 1 cycle; s_axis_tready is 0 for all sources while in IDLE.
- ACTIVE:
  - s_axis_tready[grant_index] = (!m_axis_tvalid || m_axis_tready). All other s_axis_tready bits are 0.
  - Accepted beat (tvalid&&tready on the granted source): on the next edge, the output register loads the beat's data/keep/last/user, tid=grant_index, and m_axis_tvalid=1.
  - If the output register empties without a new load, m_axis_tvalid=0.
  - Accepted beat with tlast=1: grant_valid=0, state IDLE on the same edge. Minimum 1-cycle bubble on the source side between frames; the output may still hold the last beat.
  - Granted source deasserting tvalid mid-frame: the grant is held indefinitely. No timeout, no preemption.
- Output register: behaves as a standard pipeline stage.
  - m_axis_tvalid stays high until m_axis_tready.
  - Data is stable while tvalid=1 && tready=0.
  - Throughput is 1 beat/cycle when m_axis_tready is held high.
- Fairness:
  - Pointer advances only on grant, not per beat.
  - With all S_COUNT sources continuously requesting, grants rotate 0,1,...,S_COUNT-1,0.
- S_COUNT=1: the single source is granted every frame, with the same 1-cycle IDLE bubble.
- Single-beat frame (tlast on first beat): ACTIVE lasts exactly 1 cycle if the output is ready.
- Reset mid-frame:
  - Grant, FSM and the output register clear immediately.
  - Any partially forwarded frame is truncated. Recovery is the downstream FIFO's responsibility via its own reset.
- m_axis_tid is zero-extended source index; unused upper bits are 0.

Test Plan:
1. S_COUNT=4, m_axis_tready=1, source 2 sends a 3-beat frame tdata 0xA0,0xA1,0xA2 -> grant_valid rises 1 cycle after tvalid; output is 3 consecutive beats with tid=2 and tlast only on 0xA2; grant_valid falls after the last beat.
2. All 4 sources request continuously, each sending 2-beat frames -> m_axis_tid sequence is 0,0,1,1,2,2,3,3,0,0; no interleaving within a frame.
3. Granted source 1 mid-frame with m_axis_tready=0 for 5 cycles -> m_axis_tdata and tvalid hold stable; s_axis_tready[1]=0; no beats lost or duplicated.
4. Source 3 is granted, then drops tvalid for 4 cycles mid-frame while source 0 requests -> grant remains on 3; source 0 is served only after source 3's tlast.
5. Reset asserted during the second beat of a 4-beat frame -> next cycle m_axis_tvalid=0, grant_valid=0, s_axis_tready=0; after release, source 0 wins the first arbitration.
6. S_COUNT=1, back-to-back single-beat frames -> one output beat every 2 cycles with tid=0.
